regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports, range 1..4.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wrEnable  in  2  per-write-port enable; bit i is port i.
- wrReg  in  2*ADDR_W  write indices; port i occupies slice i.
- wrData  in  2*DATA_W  write data; port i occupies slice i.
- rsvEnable  in  1  reserve request: marks rsvReg as pending.
- rsvReg  in  ADDR_W  index to reserve.
- readSelect  in  NUM_RD*ADDR_W  read indices; port k occupies slice k.
- readData  out  NUM_RD*DATA_W  read data; port k occupies slice k.
- readBusy  out  NUM_RD  pending flag of the register read on port k.
- pendingCount  out  ADDR_W+1  number of registers currently pending.

Function
REQ-003 SHALL hold 2**ADDR_W registers of DATA_W bits and one pending bit per register.
REQ-004 SHALL drive readData and readBusy combinationally from readSelect; there is no read latency.
REQ-005 SHALL hardwire register 0 to zero: writes to index 0 are discarded, reads return 0, and pending[0] is always 0.
REQ-006 SHALL write wrData slice i into register wrReg slice i on the clock edge when wrEnable[i]=1.
REQ-007 SHALL let port 1 win when both write ports target the same nonzero index in one cycle; port 0's data is discarded.
REQ-008 SHALL clear pending[r] on any accepted write to r.
REQ-009 SHALL set pending[rsvReg] on the edge when rsvEnable=1 and rsvReg is nonzero.
REQ-010 SHALL let the reservation win when rsvEnable and a write target the same index in one cycle: the data is written and pending stays 1.
REQ-011 SHALL leave pending=1 when an already-pending register is reserved again; this is not an error.
REQ-012 SHALL keep pendingCount equal to the popcount of the pending bits, updated on the same edge as those bits; its range is 0..2**ADDR_W-1.
REQ-013 SHALL return identical results when two or more read ports select the same index.

Reset
REQ-014 SHALL, while rst=0, asynchronously clear all registers, all pending bits and pendingCount to 0.
REQ-015 SHALL, as a consequence of REQ-004 and REQ-014, present readData=0 and readBusy=0 on every port during reset.
REQ-016 SHALL discard writes and reservations presented in the cycle that reset is asserted.
REQ-017 SHALL accept operations from the first rising edge after rst deasserts.

Configuration
REQ-018 SHALL support the macro REGFILE_BYPASS_EN, which controls write-to-read forwarding:
- Defined: a read of an index being written this cycle returns the incoming wrData (port 1 has priority over port 0).
- Defined: readBusy for that index shows 0, unless REQ-010 applies to the same index.
- Undefined: reads return the stored value, and the new value and cleared busy flag appear after the edge.

Structure
REQ-019 SHALL take default DATA_W, ADDR_W and NUM_WR=2, and the slice-index helper constants, from a shared package regfile_pkg.
REQ-020 SHALL implement the pending bits and pendingCount in a sub-module regfile_scoreboard, which takes write-clear and reserve-set inputs.

Verification
REQ-021 Fill test: write 16*i to reg i (i=0..31) on port 0, then read pairs (i, i+1) -> reg0 reads 0, all others read 16*i.
REQ-022 Dual-write collision: in one cycle write 0xAAAA via port 0 and 0x5555 via port 1, both to reg 7 -> reg 7 reads 0x5555.
REQ-023 Scoreboard test:
- Reserve reg 3 -> readBusy=1 and pendingCount=1.
- Write reg 3 = 9 -> busy=0, count=0, value 9.
- Reserve and write reg 3 in the same cycle -> busy=1, value written.
REQ-024 Bypass test: write reg 5 = 0x1234 while reading reg 5 in the same cycle:
- With REGFILE_BYPASS_EN -> 0x1234 in that cycle.
- Without REGFILE_BYPASS_EN -> old value in that cycle, 0x1234 after the edge.
REQ-025 Mid-operation reset: after the fill, with reg 4 reserved, assert rst between clock edges -> every output is 0 immediately, and a write in the assertion cycle is lost.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default sizes and slice helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_WR     = 2;

    // Low bit of slice idx in a bus made of equal-width slices.
    function automatic int sliceLo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register plus a live popcount of those bits.
// Latency: bits and count update together on the rising edge after clear/set inputs.
// Backpressure: none; set wins over clear on the same bit, bit 0 is never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2**ADDR_W-1:0]   clrMask,
    input  logic [2**ADDR_W-1:0]   setMask,
    output logic [2**ADDR_W-1:0]   pending,
    output logic [ADDR_W:0]        pendingCount
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pendNext;
    logic [ADDR_W:0]  countNext;

    // Next pending state (reservation beats write-clear) and its popcount.
    always_comb begin
        pendNext    = (pending & ~clrMask) | setMask;
        pendNext[0] = 1'b0;
        countNext   = '0;
        for (int r = 0; r < DEPTH; r++) begin
            countNext = countNext + {{ADDR_W{1'b0}}, pendNext[r]};
        end
    end

    // Register the bits and the count on the same edge so they never disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending      <= '0;
            pendingCount <= '0;
        end else begin
            pending      <= pendNext;
            pendingCount <= countNext;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file with two write ports, NUM_RD read ports and a pending-bit scoreboard.
// Latency: reads are combinational; writes and reservations take effect at the next edge.
// Backpressure: none; write port 1 beats port 0, reservation beats write-clear.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data (and cleared busy) to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wrEnable,
    input  logic [NUM_WR*ADDR_W-1:0]   wrReg,
    input  logic [NUM_WR*DATA_W-1:0]   wrData,
    input  logic                       rsvEnable,
    input  logic [ADDR_W-1:0]          rsvReg,
    input  logic [NUM_RD*ADDR_W-1:0]   readSelect,
    output logic [NUM_RD*DATA_W-1:0]   readData,
    output logic [NUM_RD-1:0]          readBusy,
    output logic [ADDR_W:0]            pendingCount
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  clrMask;
    logic [DEPTH-1:0]  setMask;
    logic [DEPTH-1:0]  pending;

    // Decode write ports and the reservation into one-hot clear/set masks.
    always_comb begin
        clrMask = '0;
        setMask = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wrEnable[i]) begin
                clrMask[wrReg[sliceLo(i, ADDR_W) +: ADDR_W]] = 1'b1;
            end
        end
        if (rsvEnable) begin
            setMask[rsvReg] = 1'b1;
        end
    end

    // Storage: index 0 is never written; port 1 is applied last so it wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wrEnable[i] && (wrReg[sliceLo(i, ADDR_W) +: ADDR_W] != '0)) begin
                    regs[wrReg[sliceLo(i, ADDR_W) +: ADDR_W]] <= wrData[sliceLo(i, DATA_W) +: DATA_W];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) uScoreboard (
        .clk          (clk),
        .rst          (rst),
        .clrMask      (clrMask),
        .setMask      (setMask),
        .pending      (pending),
        .pendingCount (pendingCount)
    );

    // Read ports: stored value and pending flag, optionally overridden by same-cycle writes.
    always_comb begin
        logic [ADDR_W-1:0] sel;
        readData = '0;
        readBusy = '0;
        sel      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            sel = readSelect[sliceLo(k, ADDR_W) +: ADDR_W];
            readData[sliceLo(k, DATA_W) +: DATA_W] = regs[sel];
            readBusy[k] = pending[sel];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed in reset so outputs stay at zero.
            for (int i = 0; i < NUM_WR; i++) begin
                if (rst && wrEnable[i] && (sel != '0) &&
                    (wrReg[sliceLo(i, ADDR_W) +: ADDR_W] == sel)) begin
                    readData[sliceLo(k, DATA_W) +: DATA_W] = wrData[sliceLo(i, DATA_W) +: DATA_W];
                    readBusy[k] = rsvEnable && (rsvReg == sel);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: shadow model feeds an expectation queue.
// Latency: reads are sampled 1-2 time units after stimulus settles, away from clk edges.
// Backpressure: n/a.
module tb_regfile_mp;

    logic         clk;
    logic         rst;
    logic [1:0]   wrEnable;
    logic [9:0]   wrReg;
    logic [63:0]  wrData;
    logic         rsvEnable;
    logic [4:0]   rsvReg;
    logic [9:0]   readSelect;
    logic [63:0]  readData;
    logic [1:0]   readBusy;
    logic [5:0]   pendingCount;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } expItem_t;

    expItem_t    expQ[$];
    logic [31:0] mem [32];
    logic [31:0] pendBits;
    int          checks;
    int          errors;

    regfile_mp dut (
        .clk          (clk),
        .rst          (rst),
        .wrEnable     (wrEnable),
        .wrReg        (wrReg),
        .wrData       (wrData),
        .rsvEnable    (rsvEnable),
        .rsvReg       (rsvReg),
        .readSelect   (readSelect),
        .readData     (readData),
        .readBusy     (readBusy),
        .pendingCount (pendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] v);
        expItem_t it;
        it.tag = tag;
        it.val = v;
        expQ.push_back(it);
    endtask

    task automatic popCheck(input logic [31:0] obs);
        expItem_t it;
        it = expQ.pop_front();
        checkVal(it.tag, obs, it.val);
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) mem[r] = 32'd0;
        pendBits = 32'd0;
    endtask

    // Drive one cycle of writes/reservation, then update the shadow model.
    task automatic doOp(input logic [1:0] en, input logic [4:0] r0, input logic [31:0] d0,
                        input logic [4:0] r1, input logic [31:0] d1,
                        input logic rsvE, input logic [4:0] rsvR);
        wrEnable  = en;
        wrReg     = {r1, r0};
        wrData    = {d1, d0};
        rsvEnable = rsvE;
        rsvReg    = rsvR;
        @(posedge clk);
        #1;
        wrEnable  = 2'b00;
        rsvEnable = 1'b0;
        if (en[0] && r0 != 5'd0) begin mem[r0] = d0; pendBits[r0] = 1'b0; end
        if (en[1] && r1 != 5'd0) begin mem[r1] = d1; pendBits[r1] = 1'b0; end
        if (rsvE && rsvR != 5'd0) pendBits[rsvR] = 1'b1;
    endtask

    // Read a pair of registers and compare data, busy and count against the model.
    task automatic sampleAndCheck(input string tag, input logic [4:0] a, input logic [4:0] b);
        readSelect = {b, a};
        pushExp({tag, "_d0"}, mem[a]);
        pushExp({tag, "_d1"}, mem[b]);
        pushExp({tag, "_busy0"}, {31'd0, pendBits[a]});
        pushExp({tag, "_busy1"}, {31'd0, pendBits[b]});
        pushExp({tag, "_count"}, $countones(pendBits));
        #1;
        popCheck(readData[31:0]);
        popCheck(readData[63:32]);
        popCheck({31'd0, readBusy[0]});
        popCheck({31'd0, readBusy[1]});
        popCheck({26'd0, pendingCount});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        wrEnable   = 2'b00;
        wrReg      = '0;
        wrData     = '0;
        rsvEnable  = 1'b0;
        rsvReg     = '0;
        readSelect = '0;
        modelReset();

        // Outputs while held in reset.
        #2;
        sampleAndCheck("reset", 5'd3, 5'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fill every register with 16*i through port 0, then read back in pairs.
        for (int i = 0; i < 32; i++) begin
            doOp(2'b01, 5'(i), 32'(16 * i), 5'd0, 32'd0, 1'b0, 5'd0);
        end
        for (int i = 0; i < 32; i += 2) begin
            @(posedge clk);
            #1;
            sampleAndCheck($sformatf("fill%0d", i), 5'(i), 5'(i + 1));
        end

        // Both write ports hit reg 7: port 1 must win; both read ports see the same value.
        doOp(2'b11, 5'd7, 32'h0000_AAAA, 5'd7, 32'h0000_5555, 1'b0, 5'd0);
        sampleAndCheck("collide", 5'd7, 5'd7);

        // Reservation, clear by write, and reservation winning over a same-cycle write.
        doOp(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3);
        sampleAndCheck("rsv3", 5'd3, 5'd3);
        doOp(2'b01, 5'd3, 32'd9, 5'd0, 32'd0, 1'b0, 5'd0);
        sampleAndCheck("wr3", 5'd3, 5'd2);
        doOp(2'b01, 5'd3, 32'h77, 5'd0, 32'd0, 1'b1, 5'd3);
        sampleAndCheck("rsvwr3", 5'd3, 5'd1);
        doOp(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3);
        sampleAndCheck("rsvagain", 5'd3, 5'd8);
        doOp(2'b10, 5'd0, 32'd0, 5'd0, 32'hDEAD, 1'b1, 5'd0);
        sampleAndCheck("reg0", 5'd0, 5'd3);

        // Write reg 5 while reading it in the same cycle.
        @(posedge clk);
        #1;
        readSelect = {5'd5, 5'd5};
        wrEnable   = 2'b01;
        wrReg      = {5'd0, 5'd5};
        wrData     = {32'd0, 32'h1234};
`ifdef REGFILE_BYPASS_EN
        pushExp("bypass_same", 32'h1234);
`else
        pushExp("bypass_same", mem[5]);
`endif
        pushExp("bypass_busy", 32'd0);
        #1;
        popCheck(readData[31:0]);
        popCheck({31'd0, readBusy[1]});
        @(posedge clk);
        #1;
        wrEnable = 2'b00;
        mem[5]   = 32'h1234;
        sampleAndCheck("bypass_after", 5'd5, 5'd5);

        // Reset mid-operation, with reg 4 reserved and a write in flight.
        doOp(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4);
        sampleAndCheck("prereset", 5'd4, 5'd3);
        wrEnable   = 2'b01;
        wrReg      = {5'd0, 5'd9};
        wrData     = {32'd0, 32'hBEEF};
        readSelect = {5'd9, 5'd4};
        #2;
        rst = 1'b0;
        modelReset();
        sampleAndCheck("inreset", 5'd4, 5'd9);
        @(posedge clk);
        #1;
        wrEnable = 2'b00;
        rst      = 1'b1;
        sampleAndCheck("postreset", 5'd9, 5'd4);
        doOp(2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b1, 5'd2);
        sampleAndCheck("firstop", 5'd9, 5'd2);

        checkVal("leftover", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
